// File: rtl/dffrf_mport.sv
// Parametrised flop-based multi-port register file with byte enables, optional
// registered reads, write-to-read bypass, optional hardwired zero entry and bulk clear.
module dffrf_mport #(
  parameter int unsigned  WIDTH    = 32,
  parameter int unsigned  DEPTH    = 32,
  parameter int unsigned  NR       = 3,
  parameter int unsigned  NW       = 1,
  parameter bit           READ_REG = 1'b0,
  parameter bit           BYPASS   = 1'b1,
  parameter bit           ZERO_REG = 1'b0,
  localparam int unsigned AW       = $clog2(DEPTH),
  localparam int unsigned NB       = WIDTH / 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [NR*AW-1:0]    i_ra,
  input  logic [NR-1:0]       i_re,
  output logic [NR*WIDTH-1:0] o_rd,
  input  logic [NW-1:0]       i_we,
  input  logic [NW*AW-1:0]    i_wa,
  input  logic [NW*WIDTH-1:0] i_wd,
  input  logic [NW*NB-1:0]    i_wbe,
  input  logic                i_clr,
  output logic                o_busy
);

  typedef enum logic {
    S_IDLE     = 1'b0,
    S_CLEARING = 1'b1
  } state_t;

  logic [WIDTH-1:0] r_mem     [DEPTH];
  logic [WIDTH-1:0] w_mem_nxt [DEPTH];

  state_t           r_state;
  state_t           w_state_nxt;
  logic [AW-1:0]    r_cnt;
  logic [AW-1:0]    w_cnt_nxt;
  logic             r_busy;

  logic [AW-1:0]    w_ra      [NR];
  logic [AW-1:0]    w_wa      [NW];
  logic [NR-1:0]    w_ra_rng;
  logic [NW-1:0]    w_wa_rng;
  logic [NR-1:0]    w_ra_ok;
  logic [NW-1:0]    w_wok;
  logic [WIDTH-1:0] w_rd_arr  [NR];
  logic [WIDTH-1:0] w_rd_byp  [NR];

  always_comb begin
    for (int unsigned i = 0; i < NR; i++) w_ra[i] = i_ra[i*AW +: AW];
    for (int unsigned j = 0; j < NW; j++) w_wa[j] = i_wa[j*AW +: AW];
  end

  // Address range check only exists when DEPTH leaves part of the address space unused
  if (DEPTH == (32'd1 << AW)) begin : g_full_range
    assign w_ra_rng = '1;
    assign w_wa_rng = '1;
  end else begin : g_part_range
    always_comb begin
      for (int unsigned i = 0; i < NR; i++) w_ra_rng[i] = (32'(w_ra[i]) < DEPTH);
      for (int unsigned j = 0; j < NW; j++) w_wa_rng[j] = (32'(w_wa[j]) < DEPTH);
    end
  end

  always_comb begin
    for (int unsigned j = 0; j < NW; j++) begin
      w_wok[j] = i_we[j] && w_wa_rng[j] && !(ZERO_REG && (w_wa[j] == '0));
    end
    for (int unsigned i = 0; i < NR; i++) begin
      w_ra_ok[i] = w_ra_rng[i] && !(ZERO_REG && (w_ra[i] == '0));
    end
  end

  // Next array contents: clear of entry cnt first, then user writes (higher port wins per byte)
  always_comb begin
    for (int unsigned e = 0; e < DEPTH; e++) w_mem_nxt[e] = r_mem[e];
    if (r_state == S_CLEARING) w_mem_nxt[r_cnt] = '0;
    for (int unsigned j = 0; j < NW; j++) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (w_wok[j] && i_wbe[j*NB + b]) begin
          w_mem_nxt[w_wa[j]][b*8 +: 8] = i_wd[j*WIDTH + b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int unsigned e = 0; e < DEPTH; e++) r_mem[e] <= '0;
    end else begin
      for (int unsigned e = 0; e < DEPTH; e++) r_mem[e] <= w_mem_nxt[e];
    end
  end

  // Array read plus per-byte forwarding of the winning same-cycle write
  always_comb begin
    for (int unsigned i = 0; i < NR; i++) begin
      w_rd_arr[i] = w_ra_ok[i] ? r_mem[w_ra[i]] : '0;
      w_rd_byp[i] = w_rd_arr[i];
      for (int unsigned j = 0; j < NW; j++) begin
        for (int unsigned b = 0; b < NB; b++) begin
          if (w_ra_ok[i] && w_wok[j] && i_wbe[j*NB + b] && (w_wa[j] == w_ra[i])) begin
            w_rd_byp[i][b*8 +: 8] = i_wd[j*WIDTH + b*8 +: 8];
          end
        end
      end
    end
  end

  if (READ_REG) begin : g_rd_reg
    logic [NR*WIDTH-1:0] r_rd;

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        r_rd <= '0;
      end else begin
        for (int unsigned i = 0; i < NR; i++) begin
          if (i_re[i]) r_rd[i*WIDTH +: WIDTH] <= BYPASS ? w_rd_byp[i] : w_rd_arr[i];
        end
      end
    end

    assign o_rd = r_rd;
  end else begin : g_rd_comb
    logic w_unused_re;
    assign w_unused_re = ^i_re;

    always_comb begin
      for (int unsigned i = 0; i < NR; i++) begin
        o_rd[i*WIDTH +: WIDTH] = BYPASS ? w_rd_byp[i] : w_rd_arr[i];
      end
    end
  end

  // Clear engine state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= (w_state_nxt == S_CLEARING);
    end
  end

  // Clear engine next state: walk cnt 0..DEPTH-1, CLR ignored while walking
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (i_clr) begin
          w_state_nxt = S_CLEARING;
          w_cnt_nxt   = '0;
        end
      end
      S_CLEARING: begin
        if (r_cnt == AW'(DEPTH - 1)) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + AW'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign o_busy = r_busy;

endmodule

// File: tb/tb_dffrf_mport.sv
// Scoreboard bench for dffrf_mport: instance A uses defaults (comb read, bypass),
// instance B uses NW=2, registered read-first, zero entry and DEPTH=24.
module tb_dffrf_mport;

  localparam int unsigned W  = 32;
  localparam int unsigned AW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic [3*AW-1:0] a_ra;
  logic [2:0]      a_re;
  logic [3*W-1:0]  a_rd;
  logic [0:0]      a_we;
  logic [AW-1:0]   a_wa;
  logic [W-1:0]    a_wd;
  logic [3:0]      a_wbe;
  logic            a_clr;
  logic            a_busy;

  logic [AW-1:0]   b_ra;
  logic [0:0]      b_re;
  logic [W-1:0]    b_rd;
  logic [1:0]      b_we;
  logic [2*AW-1:0] b_wa;
  logic [2*W-1:0]  b_wd;
  logic [7:0]      b_wbe;
  logic            b_clr;
  logic            b_busy;

  dffrf_mport #(.WIDTH(32), .DEPTH(32), .NR(3), .NW(1),
                .READ_REG(1'b0), .BYPASS(1'b1), .ZERO_REG(1'b0)) u_a (
    .i_clk(clk), .i_rst(rst), .i_ra(a_ra), .i_re(a_re), .o_rd(a_rd),
    .i_we(a_we), .i_wa(a_wa), .i_wd(a_wd), .i_wbe(a_wbe),
    .i_clr(a_clr), .o_busy(a_busy));

  dffrf_mport #(.WIDTH(32), .DEPTH(24), .NR(1), .NW(2),
                .READ_REG(1'b1), .BYPASS(1'b0), .ZERO_REG(1'b1)) u_b (
    .i_clk(clk), .i_rst(rst), .i_ra(b_ra), .i_re(b_re), .o_rd(b_rd),
    .i_we(b_we), .i_wa(b_wa), .i_wd(b_wd), .i_wbe(b_wbe),
    .i_clr(b_clr), .o_busy(b_busy));

  // sel: 0..2 = A read port, 3 = A busy, 4 = B read port, 5 = B busy
  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] exp;
    string       nm;
  } exp_t;

  exp_t        sb_q[$];
  int          cyc      = 0;
  int          checks   = 0;
  int          failures = 0;
  exp_t        m_e;
  logic [31:0] m_act;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] dut_val(input int sel);
    case (sel)
      0, 1, 2: return a_rd[sel*32 +: 32];
      3:       return {31'd0, a_busy};
      4:       return b_rd;
      default: return {31'd0, b_busy};
    endcase
  endfunction

  // Monitor: compare every expectation stamped for the current cycle
  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      m_e   = sb_q.pop_front();
      m_act = dut_val(m_e.sel);
      checks++;
      if (m_e.cyc != cyc || m_act !== m_e.exp) begin
        failures++;
        $display("FAIL %s: got %h required %h (cycle %0d)", m_e.nm, m_act, m_e.exp, m_e.cyc);
      end
    end
  end

  task automatic push(input int sel, input logic [31:0] v, input string nm);
    exp_t e;
    e.cyc = cyc;
    e.sel = sel;
    e.exp = v;
    e.nm  = nm;
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_rdp(input int p, input int a);
    a_ra[p*AW +: AW] = AW'(a);
  endtask

  task automatic a_wr(input int a, input logic [31:0] d, input logic [3:0] be);
    a_we  = 1'b1;
    a_wa  = AW'(a);
    a_wd  = d;
    a_wbe = be;
  endtask

  task automatic b_wr(input int p, input int a, input logic [31:0] d, input logic [3:0] be);
    b_we[p]            = 1'b1;
    b_wa[p*AW +: AW]   = AW'(a);
    b_wd[p*32 +: 32]   = d;
    b_wbe[p*4 +: 4]    = be;
  endtask

  logic [31:0] mdl_a [32];

  initial begin
    rst = 1'b1;
    a_ra = '0; a_re = '0; a_we = '0; a_wa = '0; a_wd = '0; a_wbe = '0; a_clr = 1'b0;
    b_ra = '0; b_re = '0; b_we = '0; b_wa = '0; b_wd = '0; b_wbe = '0; b_clr = 1'b0;

    tick();
    for (int p = 0; p < 3; p++) a_rdp(p, 5);
    push(0, 32'h0, "rst_a_rd");
    push(3, 32'h0, "rst_a_busy");
    push(4, 32'h0, "rst_b_rd");
    push(5, 32'h0, "rst_b_busy");
    tick();
    rst = 1'b0;
    tick();

    // Single write, same-cycle bypass, then all three ports
    a_wr(5, 32'hDEADBEEF, 4'hF);
    a_rdp(0, 5);
    push(0, 32'hDEADBEEF, "t1_bypass");
    tick();
    a_we = '0;
    for (int p = 0; p < 3; p++) begin
      a_rdp(p, 5);
      push(p, 32'hDEADBEEF, $sformatf("t1_rd%0d", p));
    end
    tick();

    // Byte enables on top of existing data
    a_wr(7, 32'hAABBCCDD, 4'hF);
    tick();
    a_wr(7, 32'h11223344, 4'b0101);
    a_rdp(0, 7);
    push(0, 32'hAA22CC44, "t2_byp_be");
    tick();
    a_we = '0;
    a_rdp(2, 7);
    push(2, 32'hAA22CC44, "t2_be_stored");
    tick();

    // Bypass only on matching address; zero byte enables write nothing
    a_wr(9, 32'h00000055, 4'hF);
    a_rdp(0, 9);
    a_rdp(1, 5);
    push(0, 32'h00000055, "t4_byp_same");
    push(1, 32'hDEADBEEF, "t4_other_addr");
    tick();
    a_wr(9, 32'hFFFFFFFF, 4'h0);
    a_rdp(2, 9);
    push(2, 32'h00000055, "t4_wbe0_byp");
    tick();
    a_we = '0;
    a_rdp(0, 9);
    push(0, 32'h00000055, "t4_wbe0_stored");
    tick();

    // Fill, then bulk clear with writes racing the engine
    for (int e = 0; e < 32; e++) begin
      a_wr(e, 32'hFFFFFFFF, 4'hF);
      tick();
    end
    a_we  = '0;
    a_clr = 1'b1;
    push(3, 32'h0, "t5_busy_clr_cycle");
    tick();
    for (int k = 0; k < 32; k++) begin
      a_we  = '0;
      a_clr = 1'b0;
      push(3, 32'h1, $sformatf("t5_busy_cnt%0d", k));
      if (k == 3) a_clr = 1'b1;
      if (k == 10) begin
        a_wr(20, 32'h12345678, 4'hF);
        a_rdp(0, 30);
        a_rdp(1, 2);
        push(0, 32'hFFFFFFFF, "t5_rd_above_cnt");
        push(1, 32'h0, "t5_rd_below_cnt");
      end
      if (k == 11) a_wr(4, 32'h0BADF00D, 4'hF);
      if (k == 15) a_wr(15, 32'hCAFEF00D, 4'hF);
      tick();
    end
    a_we  = '0;
    a_clr = 1'b0;
    push(3, 32'h0, "t5_busy_end");
    for (int e = 0; e < 32; e++) mdl_a[e] = 32'h0;
    mdl_a[4]  = 32'h0BADF00D;
    mdl_a[15] = 32'hCAFEF00D;
    for (int e = 0; e < 32; e += 3) begin
      for (int p = 0; p < 3; p++) begin
        if (e + p < 32) begin
          a_rdp(p, e + p);
          push(p, mdl_a[e+p], $sformatf("t5_entry%0d", e + p));
        end
      end
      tick();
    end

    // B: both ports on one entry, higher port wins per byte
    b_wr(0, 3, 32'h00000001, 4'hF);
    b_wr(1, 3, 32'h00000002, 4'hF);
    tick();
    b_wr(0, 4, 32'hAAAAAAAA, 4'hF);
    b_wr(1, 4, 32'hBBBBBBBB, 4'b0011);
    tick();
    b_we = '0;
    b_re = 1'b1;
    b_ra = AW'(3);
    tick();
    push(4, 32'h00000002, "t3_hi_port_wins");
    b_ra = AW'(4);
    tick();
    push(4, 32'hAAAABBBB, "t3_per_byte");

    // B: registered read-first, then new value, then hold with RE low
    b_wr(0, 9, 32'h00000055, 4'hF);
    b_ra = AW'(9);
    tick();
    push(4, 32'h0, "t4_read_first");
    b_we = '0;
    tick();
    push(4, 32'h00000055, "t4_next_read");
    b_re = 1'b0;
    b_ra = AW'(3);
    tick();
    push(4, 32'h00000055, "t4_re_hold");

    // B: zero entry and out-of-range address
    b_wr(0, 0, 32'h99999999, 4'hF);
    b_wr(1, 30, 32'h77777777, 4'hF);
    tick();
    b_we = '0;
    b_re = 1'b1;
    b_ra = AW'(0);
    tick();
    push(4, 32'h0, "zr_entry0");
    b_ra = AW'(30);
    tick();
    push(4, 32'h0, "oor_read");
    b_re = 1'b0;
    b_wr(0, 20, 32'h20202020, 4'hF);
    tick();
    b_we = '0;
    b_re = 1'b1;
    b_ra = AW'(20);
    tick();
    push(4, 32'h20202020, "t6_rd_loaded");

    // B: reset in the middle of a clear
    b_re  = 1'b0;
    b_clr = 1'b1;
    push(5, 32'h0, "t6_busy_clr_cycle");
    tick();
    b_clr = 1'b0;
    for (int k = 0; k < 12; k++) begin
      push(5, 32'h1, $sformatf("t6_busy_cnt%0d", k));
      tick();
    end
    rst = 1'b1;
    a_rdp(0, 4);
    push(5, 32'h0, "t6_rst_busy");
    push(4, 32'h0, "t6_rst_rd");
    push(0, 32'h0, "t6_rst_a_entry4");
    tick();
    rst  = 1'b0;
    b_re = 1'b1;
    b_ra = AW'(20);
    tick();
    push(4, 32'h0, "t6_entry20_zero");
    b_ra = AW'(9);
    tick();
    push(4, 32'h0, "t6_entry9_zero");
    b_re = 1'b0;
    tick();

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) tick();
    if (sb_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: got %0d pending required 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
